// File: rtl/arqte1_entrada.sv
// -----------------------------------------------------------------------------
// arqte1_entrada
//
// Avalon-MM input port peripheral with synchronizer, optional debounce
// filter, rising-edge capture and a level interrupt.
//
// Register map (word address):
//   0 data        RO   filtered input value
//   1 reserved    reads 0, writes ignored
//   2 irqmask     RW   per-bit interrupt enable
//   3 edgecapture RW1C latched rising edges
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   reset_n     asynchronous active-low reset
//   address     slave word address
//   chipselect  slave select, qualifies write_n
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     asynchronous external inputs (WIDTH bits)
//   readdata    combinational read data, zero-extended
//   irq         level interrupt, OR of (edgecapture & irqmask)
//
// Parameters:
//   WIDTH            number of input bits (1..32)
//   DEBOUNCE_CYCLES  stable clocks required by the debounce filter
//
// Build option:
//   ARQTE1_ENTRADA_DEBOUNCE_EN  when defined, each bit gets a 16-bit debounce
//                               counter; otherwise stable follows sync2.
// -----------------------------------------------------------------------------
module arqte1_entrada #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask_reg;
  logic [WIDTH-1:0] edgecapture_reg;
  logic [WIDTH-1:0] edgecapture_next;
  logic [WIDTH-1:0] clear_mask;
  logic             wr_en;

  assign wr_en = chipselect & ~write_n;

  // Two-flop synchronizer; nothing downstream sees in_port directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= in_port;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef ARQTE1_ENTRADA_DEBOUNCE_EN
  localparam logic [15:0] LIMIT = 16'(DEBOUNCE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
      logic [15:0] cnt_reg;
      logic        stable_bit_reg;

      // The counter only runs while sync2 disagrees with the filtered value;
      // any return to agreement restarts it, so short pulses never pass.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg        <= '0;
          stable_bit_reg <= 1'b0;
        end else if (sync2_reg[gi] != stable_bit_reg) begin
          if (cnt_reg == LIMIT) begin
            stable_bit_reg <= sync2_reg[gi];
            cnt_reg        <= '0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end else begin
          cnt_reg <= '0;
        end
      end

      assign stable[gi] = stable_bit_reg;
    end
  endgenerate
`else
  assign stable = sync2_reg;
`endif

  // Rising edges only; prev is stable delayed one clock.
  assign edge_det = stable & ~prev_reg;

  // A new edge on the same clock as a clear keeps the bit set.
  assign clear_mask       = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;
  assign edgecapture_next = (edgecapture_reg & ~clear_mask) | edge_det;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg        <= '0;
      edgecapture_reg <= '0;
      irqmask_reg     <= '0;
    end else begin
      prev_reg        <= stable;
      edgecapture_reg <= edgecapture_next;
      if (wr_en && (address == 2'd2)) begin
        irqmask_reg <= writedata[WIDTH-1:0];
      end
    end
  end

  // Built from registers only, so it cannot glitch on bus activity.
  assign irq = |(edgecapture_reg & irqmask_reg);

  always_comb begin
    readdata = 32'h0;
    case (address)
      2'd0:    readdata = 32'(stable);
      2'd2:    readdata = 32'(irqmask_reg);
      2'd3:    readdata = 32'(edgecapture_reg);
      default: readdata = 32'h0;
    endcase
  end

  // Upper writedata bits and the debounce length are not needed in every build.
  logic unused_ok;
  assign unused_ok = ^{writedata, DEBOUNCE_CYCLES[0]};

endmodule

// File: tb/tb_arqte1_entrada.sv
module tb_arqte1_entrada;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] exp;
    string       name;
  } sb_item_t;

  sb_item_t sb_q[$];

  arqte1_entrada #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic void sb_push(input logic [1:0] a, input logic [31:0] e, input string n);
    sb_item_t t;
    t.addr = a;
    t.exp  = e;
    t.name = n;
    sb_q.push_back(t);
  endfunction

  // Drives one bus write; signals are set mid-cycle and sampled on the next edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    $display("write addr=%0d data=%08h", a, d);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    sb_item_t t;
    reset_n = 1'b0;
    in_port = '0;
    #3;
    for (int a = 0; a < 4; a++) sb_push(2'(a), 32'h0, "reset_read");
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front();
      address = t.addr;
      #1;
      checks++;
      if (readdata !== t.exp) begin
        errors++;
        $display("FAIL %s addr=%0d got=%08h exp=%08h", t.name, t.addr, readdata, t.exp);
      end else $display("read %s addr=%0d data=%08h", t.name, t.addr, readdata);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_capture_latency;
    sb_item_t t;
    @(negedge clk);
    in_port = 4'b0101;
    // edge k samples the change
    @(posedge clk); #1;
    sb_push(2'd0, 32'h0, "data_before_k1");
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); address = t.addr; #1; checks++;
      if (readdata !== t.exp) begin errors++; $display("FAIL %s got=%08h exp=%08h", t.name, readdata, t.exp); end
      else $display("read %s data=%08h", t.name, readdata);
    end
    // edge k+1: data visible, capture not yet
    @(posedge clk); #1;
    sb_push(2'd0, 32'h5, "data_after_k1");
    sb_push(2'd3, 32'h0, "cap_before_k2");
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); address = t.addr; #1; checks++;
      if (readdata !== t.exp) begin errors++; $display("FAIL %s got=%08h exp=%08h", t.name, readdata, t.exp); end
      else $display("read %s data=%08h", t.name, readdata);
    end
    // edge k+2: capture set
    @(posedge clk); #1;
    sb_push(2'd3, 32'h5, "cap_after_k2");
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); address = t.addr; #1; checks++;
      if (readdata !== t.exp) begin errors++; $display("FAIL %s got=%08h exp=%08h", t.name, readdata, t.exp); end
      else $display("read %s data=%08h", t.name, readdata);
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got=%b exp=0", irq); end
  endtask

  task automatic test_registers;
    sb_item_t t;
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_write(2'd0, 32'h0000_000A);
    bus_write(2'd2, 32'hFFFF_FFF3);
    sb_push(2'd1, 32'h0, "reserved_ignored");
    sb_push(2'd0, 32'h5, "data_ro");
    sb_push(2'd2, 32'h3, "mask_truncated");
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); address = t.addr; #1; checks++;
      if (readdata !== t.exp) begin errors++; $display("FAIL %s got=%08h exp=%08h", t.name, readdata, t.exp); end
      else $display("read %s data=%08h", t.name, readdata);
    end
    // mask 3 with capture 5: bit 0 enables irq
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_mask3 got=%b exp=1", irq); end
    // partial clear: only bit 0 cleared
    bus_write(2'd3, 32'h1);
    sb_push(2'd3, 32'h4, "partial_clear");
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); address = t.addr; #1; checks++;
      if (readdata !== t.exp) begin errors++; $display("FAIL %s got=%08h exp=%08h", t.name, readdata, t.exp); end
      else $display("read %s data=%08h", t.name, readdata);
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_partial got=%b exp=0", irq); end
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h0);
  endtask

  task automatic test_irq;
    sb_item_t t;
    @(negedge clk);
    in_port = 4'b0000;
    cycles(4);
    bus_write(2'd3, 32'hF);      // falling edges are not captured anyway
    bus_write(2'd2, 32'h4);
    @(negedge clk);
    in_port = 4'b0100;
    cycles(2);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_capture got=%b exp=0", irq); end
    cycles(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_on_capture got=%b exp=1", irq); end
    else $display("irq asserted on bit 2 capture");
    // multiple edges collapse into one set bit
    @(negedge clk); in_port = 4'b0000; cycles(3);
    @(negedge clk); in_port = 4'b0100; cycles(4);
    sb_push(2'd3, 32'h4, "collapse");
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); address = t.addr; #1; checks++;
      if (readdata !== t.exp) begin errors++; $display("FAIL %s got=%08h exp=%08h", t.name, readdata, t.exp); end
      else $display("read %s data=%08h", t.name, readdata);
    end
    bus_write(2'd3, 32'h4);
    sb_push(2'd3, 32'h0, "w1c_bit2");
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); address = t.addr; #1; checks++;
      if (readdata !== t.exp) begin errors++; $display("FAIL %s got=%08h exp=%08h", t.name, readdata, t.exp); end
      else $display("read %s data=%08h", t.name, readdata);
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_clear got=%b exp=0", irq); end
  endtask

  task automatic test_set_wins;
    sb_item_t t;
    @(negedge clk);
    in_port = 4'b0110;           // bit 1 rises, sampled at edge k
    @(posedge clk);              // k
    @(posedge clk);              // k+1: edge_det[1] now high
    @(negedge clk);
    address    = 2'd3;
    writedata  = 32'h2;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);              // k+2: clear and set together
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("write addr=3 data=00000002 coincident with bit1 edge");
    sb_push(2'd3, 32'h2, "set_wins");
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); address = t.addr; #1; checks++;
      if (readdata !== t.exp) begin errors++; $display("FAIL %s got=%08h exp=%08h", t.name, readdata, t.exp); end
      else $display("read %s data=%08h", t.name, readdata);
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask4_cap2 got=%b exp=0", irq); end
    bus_write(2'd2, 32'h2);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_mask2_cap2 got=%b exp=1", irq); end
    bus_write(2'd3, 32'hF);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_clear_all got=%b exp=0", irq); end
  endtask

  task automatic test_reset_mid;
    sb_item_t t;
    @(negedge clk); in_port = 4'b0000; cycles(4);
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'hF);
    @(negedge clk); in_port = 4'b0011; cycles(4);
    sb_push(2'd3, 32'h3, "cap_pre_reset");
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); address = t.addr; #1; checks++;
      if (readdata !== t.exp) begin errors++; $display("FAIL %s got=%08h exp=%08h", t.name, readdata, t.exp); end
      else $display("read %s data=%08h", t.name, readdata);
    end
    @(negedge clk);
    in_port = 4'b1000;
    reset_n = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_async_drop got=%b exp=0", irq); end
    for (int a = 0; a < 4; a++) sb_push(2'(a), 32'h0, "in_reset");
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); address = t.addr; #1; checks++;
      if (readdata !== t.exp) begin errors++; $display("FAIL %s addr=%0d got=%08h exp=%08h", t.name, t.addr, readdata, t.exp); end
      else $display("read %s addr=%0d data=%08h", t.name, t.addr, readdata);
    end
    cycles(2);
    @(negedge clk);
    reset_n = 1'b1;
    cycles(3);
    sb_push(2'd3, 32'h8, "cap_after_release");
    sb_push(2'd0, 32'h8, "data_after_release");
    sb_push(2'd2, 32'h0, "mask_after_release");
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); address = t.addr; #1; checks++;
      if (readdata !== t.exp) begin errors++; $display("FAIL %s got=%08h exp=%08h", t.name, readdata, t.exp); end
      else $display("read %s data=%08h", t.name, readdata);
    end
  endtask

`ifdef ARQTE1_ENTRADA_DEBOUNCE_EN
  task automatic test_debounce;
    sb_item_t t;
    @(negedge clk); in_port = 4'b0001;
    repeat (10) @(negedge clk);
    in_port = 4'b0000;
    cycles(40);
    sb_push(2'd0, 32'h0, "short_pulse_data");
    sb_push(2'd3, 32'h0, "short_pulse_cap");
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); address = t.addr; #1; checks++;
      if (readdata !== t.exp) begin errors++; $display("FAIL %s got=%08h exp=%08h", t.name, readdata, t.exp); end
      else $display("read %s data=%08h", t.name, readdata);
    end
    @(negedge clk); in_port = 4'b0001;
    cycles(40);
    sb_push(2'd0, 32'h1, "long_level_data");
    sb_push(2'd3, 32'h1, "long_level_cap");
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); address = t.addr; #1; checks++;
      if (readdata !== t.exp) begin errors++; $display("FAIL %s got=%08h exp=%08h", t.name, readdata, t.exp); end
      else $display("read %s data=%08h", t.name, readdata);
    end
  endtask
`endif

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = '0;
    test_reset;
`ifdef ARQTE1_ENTRADA_DEBOUNCE_EN
    test_debounce;
`else
    test_capture_latency;
    test_registers;
    test_irq;
    test_set_wins;
    test_reset_mid;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arqte1_entrada.md
ARQTE1_ENTRADA -- requirements
Module: arqte1_entrada

Interface
REQ-001 Parameter WIDTH, default 4, number of input port bits (1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, stable-clock count required by the debounce filter (2..65535).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  slave select; qualifies write_n.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data.
REQ-009 in_port  input  WIDTH  asynchronous external inputs.
REQ-010 readdata  output  32  read data; zero wait states; bits above WIDTH read 0.
REQ-011 irq  output  1  level interrupt, active-high.

Function
REQ-012 Register map SHALL be: 0 = data (RO), 1 = reserved (reads 0, writes ignored), 2 = irqmask (RW), 3 = edgecapture (read / write-1-to-clear).
REQ-013 readdata SHALL be a combinational mux of the addressed register, zero-extended; address 1 or unmapped bits return 0; reads have no side effects.
REQ-014 A write SHALL occur on a clock edge where chipselect=1 and write_n=0; writes to address 0 or 1 are ignored.
REQ-015 in_port SHALL pass through a 2-flop synchronizer (sync1, sync2) per bit before any other use.
REQ-016 Filtered value "stable" SHALL drive the data register; without debounce stable = sync2.
REQ-017 A value change at in_port sampled at edge k SHALL be in sync2 after edge k+1 and readable at address 0 from then on (no debounce).
REQ-018 Rising-edge detector SHALL keep prev = stable delayed one clock; edge[i] = stable[i] & ~prev[i]; falling edges are not captured.
REQ-019 edgecapture[i] SHALL set on the edge after edge[i]=1 (edge k+2 for REQ-017 timing) and hold until cleared.
REQ-020 Write to address 3 SHALL clear every edgecapture bit whose writedata bit is 1; bits with writedata 0 are unchanged.
REQ-021 Simultaneous clear and new edge on the same bit SHALL leave the bit set (set wins).
REQ-022 Write to address 2 SHALL load irqmask <= writedata[WIDTH-1:0].
REQ-023 irq SHALL equal OR over i of (edgecapture[i] & irqmask[i]), computed from registers only (glitch-free); changes to mask or capture take effect after the same clock edge.
REQ-024 Multiple edges on a bit before clear SHALL collapse into one set bit (no count, no overflow flag).

Reset
REQ-025 Asserting reset_n=0 SHALL immediately clear sync1, sync2, stable, prev, debounce counters, irqmask and edgecapture; irq=0 and readdata at every address = 0.
REQ-026 Reset assertion mid-operation SHALL discard pending captures and in-progress debounce counts.
REQ-027 After release an in_port bit held high SHALL propagate as a normal 0->1 transition and set its edgecapture bit.

Configuration
REQ-028 Macro ARQTE1_ENTRADA_DEBOUNCE_EN defined: per-bit 16-bit counter; counter increments each clock sync2[i] != stable[i], resets to 0 when equal; when counter reaches DEBOUNCE_CYCLES-1 while still different, stable[i] <= sync2[i] and counter <= 0; pulses shorter than DEBOUNCE_CYCLES clocks SHALL never reach stable or edgecapture.
REQ-029 Macro undefined: no counters synthesized; stable = sync2; latency per REQ-017/REQ-019.

Verification
REQ-030 Reset with in_port=4'b0000, read addresses 0..3 -> all return 32'h0, irq=0.
REQ-031 No debounce: in_port 0->4'b0101 at edge k -> address 0 reads 32'h5 after edge k+1; address 3 reads 32'h5 after edge k+2; irq stays 0 (mask 0).
REQ-032 Write irqmask=4'b0100, then bit 2 rising -> irq=1 after capture edge; write 32'h4 to address 3 -> edgecapture=0 and irq=0 after that edge.
REQ-033 Clear of bit 1 issued on the same edge bit 1 edge is detected -> edgecapture[1] remains 1, irq follows mask.
REQ-034 With ARQTE1_ENTRADA_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 10-clock pulse on bit 0 -> data and edgecapture stay 0; 40-clock high level -> data bit 0 = 1 and edgecapture[0] = 1.
REQ-035 Assert reset_n low mid-debounce with edgecapture=4'b0011 and mask=4'hF -> irq drops immediately, all registers read 0; in_port held 4'b1000 across release -> edgecapture reads 32'h8 afterwards.
